// File: rtl/lerp_pkg.sv
// Shared definitions for the lerp / inv_lerp blocks.
//   - Default operand and ratio widths.
//   - Control state encoding for the inverse-lerp sequencer.
//   - Fixed-point typedefs: unsigned sample (QUx.0), signed difference
//     (one bit wider than a sample), ratio (QU0.r).
package lerp_pkg;

  localparam int DEF_INPUT_BITS      = 16;
  localparam int DEF_RATIO_FRAC_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic        [DEF_INPUT_BITS-1:0]      uin_t;
  typedef logic signed [DEF_INPUT_BITS:0]        sdiff_t;
  typedef logic        [DEF_RATIO_FRAC_BITS-1:0] ratio_t;

endpackage : lerp_pkg

// File: rtl/inv_lerp_udiv_restoring.sv
// Restoring shift/subtract fractional divider, one quotient bit per clock.
// Computes floor(dividend * 2^QUOT_BITS / divisor), which is only meaningful
// when dividend < divisor (the caller guarantees this).
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_start         load operands and begin (single-cycle pulse)
//   i_dividend      numerator magnitude
//   i_divisor       denominator magnitude (non-zero)
//   o_done          high during the clock whose edge produces the last bit
//   o_quotient      full quotient, valid while o_done is high
// QUOT_BITS must be at least 3.
module udiv_restoring #(
  parameter int DIV_BITS  = 16,
  parameter int QUOT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [DIV_BITS-1:0]  i_dividend,
  input  logic [DIV_BITS-1:0]  i_divisor,
  output logic                 o_done,
  output logic [QUOT_BITS-1:0] o_quotient
);

  localparam int CW = (QUOT_BITS > 1) ? $clog2(QUOT_BITS) : 1;

  logic                 r_busy;
  logic [DIV_BITS:0]    r_rem;     // partial remainder, always < divisor
  logic [DIV_BITS-1:0]  r_div;
  logic [QUOT_BITS-2:0] r_quot;    // bits already produced; last bit comes from w_qbit
  logic [CW-1:0]        r_count;

  logic [DIV_BITS+1:0]  w_shift;
  logic                 w_qbit;
  logic [DIV_BITS:0]    w_sub;
  logic [DIV_BITS:0]    w_rem_next;

  // Trial subtraction of the doubled remainder; the compare stands in for
  // the sign of the subtraction so the difference only needs DIV_BITS+1 bits.
  assign w_shift    = {r_rem, 1'b0};
  assign w_qbit     = (w_shift >= {2'b00, r_div});
  assign w_sub      = w_shift[DIV_BITS:0] - {1'b0, r_div};
  assign w_rem_next = w_qbit ? w_sub : w_shift[DIV_BITS:0];

  assign o_done     = r_busy && (r_count == '0);
  // The final bit is presented combinationally so the caller can capture
  // the complete quotient on the same edge that finishes the divide.
  assign o_quotient = {r_quot, w_qbit};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_rem   <= '0;
      r_div   <= '0;
      r_quot  <= '0;
      r_count <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_rem   <= {1'b0, i_dividend};
      r_div   <= i_divisor;
      r_quot  <= '0;
      r_count <= CW'(QUOT_BITS - 1);
    end else if (r_busy) begin
      r_rem   <= w_rem_next;
      r_quot  <= {r_quot[QUOT_BITS-3:0], w_qbit};
      r_count <= r_count - 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule : udiv_restoring

// File: rtl/inv_lerp.sv
// Inverse linear interpolation: ratio = floor((x-inb) * 2^r / (ina-inb)),
// so that lerp(ina, inb, ratio) lands on x (rounded toward inb).
// Out-of-range samples are classified on the accept edge and answered in
// one cycle; in-range samples go through a sequential restoring divider.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake (ready only in IDLE, out of reset)
//   ina, inb, x       endpoints (ratio 1.0 / 0.0) and sample, QUx.0
//   out_valid/ready   result handshake; result held until taken
//   ratio             QU0.r result
//   saturated         x at or beyond ina, ratio forced to all-ones
//   degenerate        ina == inb, ratio forced to zero
module inv_lerp
  import lerp_pkg::*;
#(
  parameter int INPUT_BITS      = DEF_INPUT_BITS,
  parameter int RATIO_FRAC_BITS = DEF_RATIO_FRAC_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INPUT_BITS-1:0]      ina,
  input  logic [INPUT_BITS-1:0]      inb,
  input  logic [INPUT_BITS-1:0]      x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RATIO_FRAC_BITS-1:0] ratio,
  output logic                       saturated,
  output logic                       degenerate
);

  state_t r_state;
  state_t w_state_next;

  logic [RATIO_FRAC_BITS-1:0] r_ratio;
  logic                       r_saturated;
  logic                       r_degenerate;

  logic                       w_accept;
  logic [INPUT_BITS:0]        w_d;        // ina - inb, two's complement
  logic [INPUT_BITS:0]        w_n;        // x   - inb, two's complement
  logic [INPUT_BITS-1:0]      w_d_mag;
  logic [INPUT_BITS-1:0]      w_n_mag;
  logic                       w_is_degen;
  logic                       w_is_below;
  logic                       w_is_sat;
  logic                       w_div_start;
  logic                       w_div_done;
  logic [RATIO_FRAC_BITS-1:0] w_div_quot;

  assign in_ready  = (r_state == IDLE) && !reset;
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;

  // Differences on zero-extended operands; the top bit is the sign.
  // A magnitude never exceeds 2^INPUT_BITS-1, so it fits the input width.
  assign w_d     = {1'b0, ina} - {1'b0, inb};
  assign w_n     = {1'b0, x}   - {1'b0, inb};
  assign w_d_mag = w_d[INPUT_BITS] ? (~w_d[INPUT_BITS-1:0] + 1'b1) : w_d[INPUT_BITS-1:0];
  assign w_n_mag = w_n[INPUT_BITS] ? (~w_n[INPUT_BITS-1:0] + 1'b1) : w_n[INPUT_BITS-1:0];

  // Classification, highest priority first: degenerate, on/behind inb,
  // at/beyond ina. Only what is left needs the divider.
  assign w_is_degen = (w_d == '0);
  assign w_is_below = (w_n == '0) || (w_n[INPUT_BITS] != w_d[INPUT_BITS]);
  assign w_is_sat   = (w_n_mag >= w_d_mag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every combinational output is given a default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_div_start  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_degen || w_is_below || w_is_sat) begin
            w_state_next = DONE;
          end else begin
            w_state_next = CALC;
            w_div_start  = 1'b1;
          end
        end
      end
      CALC:    if (w_div_done) w_state_next = DONE;
      DONE:    if (out_ready)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Flags clear on every accept; ratio changes only when a new result lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ratio      <= '0;
      r_saturated  <= 1'b0;
      r_degenerate <= 1'b0;
    end else if (w_accept) begin
      r_saturated  <= 1'b0;
      r_degenerate <= 1'b0;
      if (w_is_degen) begin
        r_ratio      <= '0;
        r_degenerate <= 1'b1;
      end else if (w_is_below) begin
        r_ratio      <= '0;
      end else if (w_is_sat) begin
        r_ratio      <= '1;
        r_saturated  <= 1'b1;
      end
    end else if ((r_state == CALC) && w_div_done) begin
      r_ratio <= w_div_quot;
    end
  end

  udiv_restoring #(
    .DIV_BITS  (INPUT_BITS),
    .QUOT_BITS (RATIO_FRAC_BITS)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_dividend (w_n_mag),
    .i_divisor  (w_d_mag),
    .o_done     (w_div_done),
    .o_quotient (w_div_quot)
  );

  assign ratio      = r_ratio;
  assign saturated  = r_saturated;
  assign degenerate = r_degenerate;

endmodule : inv_lerp

// File: tb/tb_inv_lerp.sv
module tb_inv_lerp;
  import lerp_pkg::*;

  localparam int IW = DEF_INPUT_BITS;
  localparam int RW = DEF_RATIO_FRAC_BITS;
  localparam int N_RANDOM = 4000;

  logic   clk = 1'b0;
  logic   reset;
  logic   in_valid;
  logic   in_ready;
  uin_t   ina, inb, x;
  logic   out_valid;
  logic   out_ready;
  ratio_t ratio;
  logic   saturated;
  logic   degenerate;

  typedef struct packed {
    ratio_t ratio;
    logic   sat;
    logic   deg;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  inv_lerp #(
    .INPUT_BITS      (IW),
    .RATIO_FRAC_BITS (RW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ina        (ina),
    .inb        (inb),
    .x          (x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ratio      (ratio),
    .saturated  (saturated),
    .degenerate (degenerate)
  );

  // Reference: plain integer arithmetic on the mathematical definition.
  function automatic exp_t model(input uin_t a, input uin_t b, input uin_t xs);
    exp_t   e;
    longint d, n, ad, an;
    e  = '0;
    d  = longint'(a) - longint'(b);
    n  = longint'(xs) - longint'(b);
    ad = (d < 0) ? -d : d;
    an = (n < 0) ? -n : n;
    if (d == 0) begin
      e.deg = 1'b1;
    end else if (n == 0 || ((n < 0) != (d < 0))) begin
      e.ratio = '0;
    end else if (an >= ad) begin
      e.ratio = '1;
      e.sat   = 1'b1;
    end else begin
      e.ratio = RW'((an << RW) / ad);
    end
    return e;
  endfunction

  // Waits (bounded) for in_ready, presents one operand set for exactly one
  // accept edge, records the expected result, returns on the next negedge.
  task automatic send(input uin_t a, input uin_t b, input uin_t xs);
    int guard;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL send_ready_timeout: in_ready=%b, required 1", in_ready);
    end
    ina      = a;
    inb      = b;
    x        = xs;
    in_valid = 1'b1;
    sb_q.push_back(model(a, b, xs));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    ok = (out_valid === 1'b1);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ina = '0; inb = '0; x = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
    end
    n_vec++;
    if ({ratio, saturated, degenerate} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ratio=%0d sat=%b deg=%b, required 0 0 0", ratio, saturated, degenerate);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  // Divide-path results appear RW rising edges after the accept edge;
  // special cases are already valid in the cycle right after accept.
  task automatic test_directed();
    uin_t va[9];
    uin_t vb[9];
    uin_t vx[9];
    int   vl[9];
    int   lat;
    bit   ok;
    exp_t e;
    va = '{16'd1000, 16'd0,    16'd0,    16'd0, 16'd4000, 16'd1000, 16'd1000, 16'd65535, 16'd1000};
    vb = '{16'd0,    16'd1000, 16'd1000, 16'd1000, 16'd4000, 16'd0, 16'd500,  16'd0,     16'd0};
    vx = '{16'd500,  16'd750,  16'd1000, 16'd0, 16'd17,   16'd1000, 16'd100,  16'd65534, 16'd1};
    vl = '{RW,       RW,       0,        0,     0,        0,        0,        RW,        RW};
    for (int i = 0; i < 9; i++) begin
      send(va[i], vb[i], vx[i]);
      wait_out(lat, ok);
      e = sb_q.pop_front();
      n_vec++;
      if (!ok || lat != vl[i]) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: %0d edges (valid=%b), required %0d", i, lat, ok, vl[i]);
      end
      n_vec++;
      if ({ratio, saturated, degenerate} !== {e.ratio, e.sat, e.deg}) begin
        n_err++;
        $display("FAIL directed_result[%0d]: ratio=%0d sat=%b deg=%b, required ratio=%0d sat=%b deg=%b",
                 i, ratio, saturated, degenerate, e.ratio, e.sat, e.deg);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    bit   ok;
    exp_t e;
    out_ready = 1'b0;
    send(16'd1000, 16'd0, 16'd250);
    wait_out(lat, ok);
    e = sb_q.pop_front();
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL hold_timeout: out_valid=%b, required 1", out_valid);
    end
    // A degenerate request is offered throughout; it must not be taken.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      ina = 16'd7; inb = 16'd7; x = 16'd7;
      n_vec++;
      if ({out_valid, in_ready, ratio, saturated, degenerate} !== {2'b10, e.ratio, e.sat, e.deg}) begin
        n_err++;
        $display("FAIL hold_cycle[%0d]: out_valid=%b in_ready=%b ratio=%0d sat=%b deg=%b, required 1 0 %0d %b %b",
                 i, out_valid, in_ready, ratio, saturated, degenerate, e.ratio, e.sat, e.deg);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  // Runs after test_backpressure, so the standing ratio is 64.
  task automatic test_reset_mid_calc();
    int   lat;
    bit   ok;
    bit   seen;
    exp_t e;
    send(16'd1000, 16'd0, 16'd500);
    repeat (3) @(negedge clk);
    n_vec++;
    if ({out_valid, ratio} !== {1'b0, ratio_t'(64)}) begin
      n_err++;
      $display("FAIL calc_ratio_kept: out_valid=%b ratio=%0d, required 0 64", out_valid, ratio);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, in_ready, ratio, saturated, degenerate} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: out_valid=%b in_ready=%b ratio=%0d sat=%b deg=%b, required all 0",
               out_valid, in_ready, ratio, saturated, degenerate);
    end
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_discard: stray out_valid=%b in_ready=%b, required 0 1", seen, in_ready);
    end
    send(16'd1000, 16'd0, 16'd500);
    wait_out(lat, ok);
    e = sb_q.pop_front();
    n_vec++;
    if (!ok || lat != RW || {ratio, saturated, degenerate} !== {e.ratio, e.sat, e.deg}) begin
      n_err++;
      $display("FAIL after_abort: valid=%b lat=%0d ratio=%0d sat=%b deg=%b, required 1 %0d %0d %b %b",
               ok, lat, ratio, saturated, degenerate, RW, e.ratio, e.sat, e.deg);
    end
    @(negedge clk);
  endtask

  // in_valid and out_ready held high: accepts must be RW+2 cycles apart and
  // results drain through the scoreboard in order.
  task automatic test_back_to_back();
    uin_t ta[4];
    uin_t tb[4];
    uin_t tx[4];
    int   acc, res, cyc, last;
    bit   acc_now;
    exp_t e;
    ta = '{16'd1000, 16'd0,    16'd300, 16'd60000};
    tb = '{16'd0,    16'd1000, 16'd200, 16'd100};
    tx = '{16'd999,  16'd500,  16'd201, 16'd30000};
    acc = 0; res = 0; cyc = 0; last = -1;
    out_ready = 1'b1;
    @(negedge clk);
    ina = ta[0]; inb = tb[0]; x = tx[0];
    in_valid = 1'b1;
    while (res < 4 && cyc < 200) begin
      acc_now = 1'b0;
      if (out_valid === 1'b1) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_unexpected: out_valid with empty scoreboard, required none");
        end else begin
          e = sb_q.pop_front();
          if ({ratio, saturated, degenerate} !== {e.ratio, e.sat, e.deg}) begin
            n_err++;
            $display("FAIL b2b_result[%0d]: ratio=%0d sat=%b deg=%b, required %0d %b %b",
                     res, ratio, saturated, degenerate, e.ratio, e.sat, e.deg);
          end
        end
        res++;
      end
      if (in_ready === 1'b1 && in_valid) begin
        sb_q.push_back(model(ina, inb, x));
        if (last >= 0) begin
          n_vec++;
          if (cyc - last != RW + 2) begin
            n_err++;
            $display("FAIL b2b_spacing[%0d]: %0d cycles, required %0d", acc, cyc - last, RW + 2);
          end
        end
        last    = cyc;
        acc++;
        acc_now = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (acc_now) begin
        if (acc < 4) begin
          ina = ta[acc]; inb = tb[acc]; x = tx[acc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    n_vec++;
    if (res != 4) begin
      n_err++;
      $display("FAIL b2b_timeout: %0d results, required 4", res);
    end
  endtask

  task automatic test_random();
    uin_t   a, b, xs, lo, hi;
    int     lat;
    bit     ok;
    exp_t   e;
    longint ad, an, slack;
    for (int i = 0; i < N_RANDOM; i++) begin
      do begin
        a = uin_t'($urandom_range(0, 65535));
        b = uin_t'($urandom_range(0, 65535));
      end while ((a > b ? a - b : b - a) < 2);
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      xs = uin_t'($urandom_range(int'(hi) - 1, int'(lo) + 1));
      send(a, b, xs);
      wait_out(lat, ok);
      e = sb_q.pop_front();
      n_vec++;
      if (!ok || {ratio, saturated, degenerate} !== {e.ratio, e.sat, e.deg}) begin
        n_err++;
        $display("FAIL random_result[%0d] a=%0d b=%0d x=%0d: valid=%b ratio=%0d sat=%b deg=%b, required %0d %b %b",
                 i, a, b, xs, ok, ratio, saturated, degenerate, e.ratio, e.sat, e.deg);
      end
      // Round trip: |d|*ratio/2^r must sit between inb and x, less than
      // one ratio step short of x.
      ad    = (a > b) ? longint'(a - b) : longint'(b - a);
      an    = (xs > b) ? longint'(xs - b) : longint'(b - xs);
      slack = (an << RW) - ad * longint'(ratio);
      n_vec++;
      if (slack < 0 || slack >= ad) begin
        n_err++;
        $display("FAIL random_roundtrip[%0d] a=%0d b=%0d x=%0d: ratio=%0d slack=%0d, required 0..%0d",
                 i, a, b, xs, ratio, slack, ad - 1);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_inv_lerp
